// File: rtl/mux_arbiter.sv
// Round-robin arbiter that shares a 2:1 mux between two level requesters.
// It enforces a bounded hold time, and a dead SWITCH cycle lets sel settle before the new grant.
module mux_arbiter #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = $clog2(HOLD_MAX)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  output logic [1:0]       grant,
  output logic             sel,
  output logic             preempt,
  output logic [CNT_W-1:0] hold_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT0   = 2'd1,
    GNT1   = 2'd2,
    SWITCH = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(HOLD_MAX - 1);

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic [1:0]       grant_q, grant_d;
  logic             sel_q, sel_d;
  logic             preempt_q, preempt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             curIdx;

  assign curIdx = (state_q == GNT1);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    preempt_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        unique case (req)
          2'b01:   state_d = GNT0;
          2'b10:   state_d = GNT1;
          2'b11:   state_d = last_q ? GNT0 : GNT1;
          default: state_d = IDLE;
        endcase
      end
      GNT0, GNT1: begin
        if (!req[curIdx]) begin
          last_d  = curIdx;
          state_d = req[~curIdx] ? SWITCH : IDLE;
        end else if (req[~curIdx] && (cnt_q == CntMax)) begin
          last_d    = curIdx;
          state_d   = SWITCH;
          preempt_d = 1'b1;
        end
      end
      SWITCH: state_d = req[~last_q] ? (last_q ? GNT0 : GNT1) : IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    grant_d = 2'b00;
    sel_d   = sel_q;
    cnt_d   = '0;
    unique case (state_d)
      GNT0: begin
        grant_d = 2'b01;
        sel_d   = 1'b0;
      end
      GNT1: begin
        grant_d = 2'b10;
        sel_d   = 1'b1;
      end
      SWITCH:  sel_d = ~last_d;
      default: sel_d = sel_q;
    endcase
    if ((state_d == state_q) && (state_q == GNT0 || state_q == GNT1)) begin
      cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      grant_q   <= 2'b00;
      sel_q     <= 1'b0;
      preempt_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      preempt_q <= preempt_d;
      cnt_q     <= cnt_d;
    end
  end

  assign grant    = grant_q;
  assign sel      = sel_q;
  assign preempt  = preempt_q;
  assign hold_cnt = cnt_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Scenario bench for mux_arbiter: expected outputs are queued as each cycle is driven.
// Each scenario then compares them against the sampled outputs.
module tb_mux_arbiter;

  typedef struct packed {
    logic [1:0] grant;
    logic       sel;
    logic       preempt;
    logic [2:0] cnt;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req = 2'b00;
  logic [1:0] grant;
  logic       sel;
  logic       preempt;
  logic [2:0] hold_cnt;

  int errors = 0;
  int checks = 0;
  obs_t expQ[$];
  obs_t obsQ[$];

  mux_arbiter #(.HOLD_MAX(8), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .grant(grant), .sel(sel), .preempt(preempt), .hold_cnt(hold_cnt)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(logic [1:0] g, logic s, logic p, int c);
    obs_t v;
    v.grant = g; v.sel = s; v.preempt = p; v.cnt = 3'(c);
    return v;
  endfunction

  function automatic string fmt(obs_t v);
    return $sformatf("grant=%b sel=%b preempt=%b hold_cnt=%0d", v.grant, v.sel, v.preempt, v.cnt);
  endfunction

  // Drive one cycle of stimulus, queue its expectation, and sample just after the edge.
  task automatic step(input logic [1:0] r, input logic rn, input obs_t e);
    @(negedge clk);
    req = r;
    rst_n = rn;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    obsQ.push_back(mk(grant, sel, preempt, int'(hold_cnt)));
  endtask

  task automatic test_reset();
    obs_t e, o;
    int n = 0;
    step(2'b00, 1'b0, mk(2'b00, 0, 0, 0));
    repeat (5) step(2'b00, 1'b1, mk(2'b00, 0, 0, 0));
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL reset[%0d]: got %s, want %s", n, fmt(o), fmt(e));
      end
      n++;
    end
  endtask

  task automatic test_single_hold();
    obs_t e, o;
    int n = 0;
    for (int k = 0; k < 20; k++) step(2'b01, 1'b1, mk(2'b01, 0, 0, (k > 7) ? 7 : k));
    step(2'b00, 1'b1, mk(2'b00, 0, 0, 0));
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL single_hold[%0d]: got %s, want %s", n, fmt(o), fmt(e));
      end
      n++;
    end
  endtask

  task automatic test_contention();
    obs_t e, o;
    int n = 0;
    step(2'b11, 1'b0, mk(2'b00, 0, 0, 0));
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 8; k++)
        step(2'b11, 1'b1, mk((r == 1) ? 2'b10 : 2'b01, r[0], 0, k));
      step(2'b11, 1'b1, mk(2'b00, ~r[0], 1, 0));
    end
    step(2'b11, 1'b1, mk(2'b01, 0, 0, 0));
    step(2'b00, 1'b1, mk(2'b00, 0, 0, 0));
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL contention[%0d]: got %s, want %s", n, fmt(o), fmt(e));
      end
      n++;
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, o;
    int n = 0;
    step(2'b10, 1'b1, mk(2'b10, 1, 0, 0));
    for (int k = 1; k <= 3; k++) step(2'b11, 1'b1, mk(2'b10, 1, 0, k));
    step(2'b01, 1'b1, mk(2'b00, 0, 0, 0));
    step(2'b01, 1'b1, mk(2'b01, 0, 0, 0));
    step(2'b00, 1'b1, mk(2'b00, 0, 0, 0));
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL back_to_back[%0d]: got %s, want %s", n, fmt(o), fmt(e));
      end
      n++;
    end
  endtask

  task automatic test_switch_drop();
    obs_t e, o;
    int n = 0;
    step(2'b11, 1'b1, mk(2'b10, 1, 0, 0));
    for (int k = 1; k < 8; k++) step(2'b11, 1'b1, mk(2'b10, 1, 0, k));
    step(2'b11, 1'b1, mk(2'b00, 0, 1, 0));
    step(2'b10, 1'b1, mk(2'b00, 0, 0, 0));
    step(2'b10, 1'b1, mk(2'b10, 1, 0, 0));
    step(2'b00, 1'b1, mk(2'b00, 1, 0, 0));
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL switch_drop[%0d]: got %s, want %s", n, fmt(o), fmt(e));
      end
      n++;
    end
  endtask

  task automatic test_reset_mid_grant();
    obs_t e, o;
    int n = 0;
    for (int k = 0; k <= 5; k++) step(2'b10, 1'b1, mk(2'b10, 1, 0, k));
    step(2'b11, 1'b0, mk(2'b00, 0, 0, 0));
    step(2'b11, 1'b1, mk(2'b01, 0, 0, 0));
    step(2'b00, 1'b1, mk(2'b00, 0, 0, 0));
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL reset_mid_grant[%0d]: got %s, want %s", n, fmt(o), fmt(e));
      end
      n++;
    end
  endtask

  initial begin
    test_reset();
    test_single_hold();
    test_contention();
    test_back_to_back();
    test_switch_drop();
    test_reset_mid_grant();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Sequential arbiter sharing the 2:1 `mux` between two requesters. Each requester raises a level request and owns the mux while granted. The block drives the mux `sel` line and a one-hot grant. Handover is round-robin with a bounded hold time and a one-cycle break-before-make gap, so `sel` settles before the new owner is granted.

## Interface
- `HOLD_MAX`, 8: maximum consecutive grant cycles for one owner while the other requester waits. Legal range ≥ 2.
- `CNT_W`, `$clog2(HOLD_MAX)`: width of the hold counter.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset, sampled on `clk` rising edge.
- `req` input 2: `req[i]` high means requester i wants the mux. Level-held until done.
- `grant` output 2: one-hot or zero. `grant[i]` means requester i owns the mux.
- `sel` output 1: drives `mux.sel`. Equals the current or incoming owner index.
- `preempt` output 1: one-cycle pulse when an owner is forced off by hold timeout.
- `hold_cnt` output CNT_W: grant cycles elapsed for the current owner, minus 1.

## Operation
- States:
  - IDLE: no owner.
  - GNT0 / GNT1: the indicated requester owns the mux.
  - SWITCH: one dead cycle before handover.
- All outputs are registered. Next-state logic samples `req` at each rising edge.
- Reset (`rst_n`=0 at an edge) takes effect from that edge and overrides any state, including mid-grant or mid-SWITCH:
  - state=IDLE, `grant`=00, `sel`=0, `preempt`=0, `hold_cnt`=0.
  - `last` owner register = 1, so requester 0 wins the first tie.
- IDLE:
  - `req`=00: stay; `sel` holds its last value.
  - Exactly one bit set: go to GNTi; `sel`←i.
  - `req`=11: grant the index ≠ `last`.
- GNTi:
  - Outputs: `grant[i]`=1, `sel`=i.
  - `hold_cnt` is 0 on the first grant cycle, increments each cycle, and saturates at HOLD_MAX-1.
  - `req[i]`=0 and `req[~i]`=0: go to IDLE.
  - `req[i]`=0 and `req[~i]`=1: go to SWITCH.
  - `req[i]`=1, `req[~i]`=1, and `hold_cnt`==HOLD_MAX-1: go to SWITCH and pulse `preempt` for the SWITCH cycle.
  - Otherwise stay. A lone requester holds indefinitely; `hold_cnt` stays saturated.
- On every exit from GNTi: `last`←i.
- SWITCH:
  - Outputs: `grant`=00; `sel` already set to target t=~`last` on entry.
  - `req[t]`=1: go to GNTt.
  - `req[t]`=0: go to IDLE. `sel` keeps t and is re-arbitrated from IDLE next cycle.
- A requester whose `req` is preempted while still high re-competes. It is guaranteed the next grant after the other owner releases or times out.
- `grant` is never 11. `sel` never changes in the same cycle a grant is active for a different index.

## Timing
- Request to grant from IDLE: 1 cycle. `req` is seen at edge k; `grant` and `sel` update at edge k.
- Release: `req[i]` low at edge k makes `grant[i]`=0 from edge k.
- Handover: the release edge enters SWITCH (`sel` flips). The next edge asserts the new grant. The other requester gets its grant 2 edges after the release is sampled.
- Preempted owner: holds `grant` exactly HOLD_MAX cycles while contended.
- `preempt` is high only during the SWITCH cycle that follows a timeout. It is never high during a voluntary release.
- `hold_cnt` resets to 0 on entry to GNTx and reads 0 in IDLE and SWITCH.

## Test plan
- Reset, then `req`=00 for 5 cycles: required `grant`=00, `sel`=0, `preempt`=0, `hold_cnt`=0 throughout.
- `req`=01 from reset: `grant`=01 next edge with `sel`=0. Hold 20 cycles: grant is stable, `hold_cnt` saturates at 7, no preempt. Drop `req`: `grant`=00 next edge.
- `req`=11 simultaneously from IDLE after reset:
  - `grant`=01 for exactly 8 cycles.
  - Then one SWITCH cycle: `grant`=00, `sel`=1, `preempt`=1.
  - Then `grant`=10 for 8 cycles; the alternation repeats.
- Requester 1 owns the mux and requester 0 requests, then requester 1 drops `req` at `hold_cnt`=3. Required: SWITCH (`preempt`=0, `sel`=0), then `grant`=01.
- Requester 0 drops `req` during the SWITCH cycle that targets it: state returns to IDLE with `grant`=00. If `req[1]` is still high, `grant`=10 on the following edge.
- `rst_n` low mid-GNT1 with `hold_cnt`=5: all outputs return to reset values at that edge. After release with `req`=11, `grant`=01 first.
